// File: rtl/picomips_pkg.sv
// Shared constants and helpers for the picoMIPS front end.
package picomips_pkg;

    localparam int PSIZE_DEFAULT = 5;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pc_sequencer_sw_debounce.sv
// Two-flop synchronizer plus stable-count debouncer for one board switch.
module sw_debounce
    import picomips_pkg::*;
#(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic edge_p
);

    localparam int CW = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] TERM = CW'(DB_CYCLES - 1);

    logic          s1_q, s2_q;
    logic          level_q, level_d;
    logic          edge_q, edge_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any return of s2 to the current level drops the partial count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        edge_d  = 1'b0;
        if (s2_q != level_q) begin
            if (cnt_q == TERM) begin
                level_d = s2_q;
                edge_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            level_q <= 1'b0;
            edge_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= raw;
            s2_q    <= s1_q;
            level_q <= level_d;
            edge_q  <= edge_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level  = level_q;
    assign edge_p = edge_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with wrap/park end handling and debounced Switch8 level.
module pc_sequencer
    import picomips_pkg::*;
#(
    parameter int PSIZE     = PSIZE_DEFAULT,
    parameter int LAST_ADDR = 2**PSIZE - 1,
    parameter int WRAP      = 1,
    parameter int DB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PCup,
    input  logic             sw8_raw,
    output logic [PSIZE-1:0] PCout,
    output logic             Switch8,
    output logic             sw8_edge,
    output logic             done
);

    localparam logic [PSIZE-1:0] LAST = PSIZE'(LAST_ADDR);

    logic [PSIZE-1:0] pc_q, pc_d;
    logic             done_q, done_d;

    // Once parked, the strobe is ignored until reset.
    always_comb begin
        pc_d   = pc_q;
        done_d = done_q;
        if (PCup && !done_q) begin
            if (pc_q >= LAST) begin
                if (WRAP != 0) begin
                    pc_d = '0;
                end else begin
                    pc_d   = LAST;
                    done_d = 1'b1;
                end
            end else begin
                pc_d = pc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q   <= '0;
            done_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            done_q <= done_d;
        end
    end

    assign PCout = pc_q;
    assign done  = done_q;

    sw_debounce #(
        .DB_CYCLES(DB_CYCLES)
    ) u_db (
        .clk   (clk),
        .reset (reset),
        .raw   (sw8_raw),
        .level (Switch8),
        .edge_p(sw8_edge)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer: wrapping and parking instances vs a reference model.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pcup0 = 1'b0;
    logic       pcup1 = 1'b0;
    logic       sw_raw = 1'b0;
    logic [4:0] pc0, pc1;
    logic       sw0, sw1, edg0, edg1, done0, done1;

    int checks = 0;
    int errors = 0;

    int m_pc0, m_pc1;
    bit m_done1, m_sw, m_edge;
    bit hist[$];

    always #5 clk = ~clk;

    pc_sequencer #(
        .PSIZE(5), .LAST_ADDR(31), .WRAP(1), .DB_CYCLES(16)
    ) u_wrap (
        .clk(clk), .reset(reset), .PCup(pcup0), .sw8_raw(sw_raw),
        .PCout(pc0), .Switch8(sw0), .sw8_edge(edg0), .done(done0)
    );

    pc_sequencer #(
        .PSIZE(5), .LAST_ADDR(9), .WRAP(0), .DB_CYCLES(16)
    ) u_park (
        .clk(clk), .reset(reset), .PCup(pcup1), .sw8_raw(sw_raw),
        .PCout(pc1), .Switch8(sw1), .sw8_edge(edg1), .done(done1)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("pc_wrap", int'(pc0), m_pc0);
        check("pc_park", int'(pc1), m_pc1);
        check("done_wrap", int'(done0), 0);
        check("done_park", int'(done1), int'(m_done1));
        check("sw8_wrap", int'(sw0), int'(m_sw));
        check("sw8_park", int'(sw1), int'(m_sw));
        check("edge_wrap", int'(edg0), int'(m_edge));
        check("edge_park", int'(edg1), int'(m_edge));
    endtask

    // Switch8 flips when the last 16 synchronized samples all differ from it;
    // the synchronized sample at edge N is the raw value sampled at edge N-2.
    task automatic step();
        int n;
        bit flip;
        n = hist.size();
        flip = (n >= 17);
        for (int k = 2; k <= 17; k++)
            if (n >= k && hist[n-k] == m_sw) flip = 1'b0;
        m_edge = flip;
        if (flip) m_sw = ~m_sw;
        hist.push_back(sw_raw);
        if (hist.size() > 40) void'(hist.pop_front());
        if (pcup0) m_pc0 = (m_pc0 + 1) % 32;
        if (pcup1 && !m_done1) begin
            if (m_pc1 == 9) m_done1 = 1'b1;
            else m_pc1 = m_pc1 + 1;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        m_pc0 = 0; m_pc1 = 0; m_done1 = 0; m_sw = 0; m_edge = 0;
        hist.delete();
        #2;
        check("rst_pc_async", int'(pc0), 0);
        check("rst_sw_async", int'(sw0), 0);
        check_all();
        #1 reset = 1'b0;
    endtask

    task automatic wait_rise(input string tag, input int exp_lat);
        int cnt = 0;
        bit prev;
        prev = sw0;
        while (sw0 == prev && cnt < 40) begin
            step();
            cnt++;
        end
        check(tag, cnt, exp_lat);
    endtask

    initial begin
        int pulses;
        int run;
        @(posedge clk);
        #1;
        do_reset();

        pcup0 = 1'b1; pcup1 = 1'b1;
        repeat (9) step();
        check("park_at9_pc", int'(pc1), 9);
        check("park_at9_done", int'(done1), 0);
        step();
        check("park_done", int'(done1), 1);
        repeat (23) step();
        check("wrap_33", int'(pc0), 1);
        check("park_hold", int'(pc1), 9);

        @(negedge clk);
        do_reset();
        repeat (4) step();
        pcup0 = 1'b0; pcup1 = 1'b0;
        repeat (5) step();
        check("stall_pc", int'(pc0), 4);
        pcup0 = 1'b1; pcup1 = 1'b1;
        step();
        check("stall_resume", int'(pc0), 5);
        pcup0 = 1'b0; pcup1 = 1'b0;

        repeat (20) step();
        sw_raw = 1'b1;
        wait_rise("sw_rise_lat", 18);
        check("sw_rise_edge", int'(edg0), 1);
        step();
        check("sw_edge_one", int'(edg0), 0);
        repeat (5) step();
        sw_raw = 1'b0;
        wait_rise("sw_fall_lat", 18);
        repeat (20) step();

        pulses = 0;
        for (int b = 0; b < 3; b++) begin
            sw_raw = 1'b1;
            repeat (10) begin step(); pulses += int'(edg0); end
            sw_raw = 1'b0;
            repeat (10) begin step(); pulses += int'(edg0); end
        end
        check("bounce_level", int'(sw0), 0);
        sw_raw = 1'b1;
        repeat (40) begin step(); pulses += int'(edg0); end
        check("bounce_pulses", pulses, 1);
        check("bounce_level_hi", int'(sw0), 1);

        sw_raw = 1'b0;
        repeat (25) step();
        pcup0 = 1'b1;
        sw_raw = 1'b1;
        repeat (8) step();
        pcup0 = 1'b0;
        do_reset();
        check("rst_mid_pc", int'(pc0), 0);
        wait_rise("rst_mid_lat", 18);

        for (int i = 0; i < 30; i++) begin
            sw_raw = 1'($urandom_range(0, 1));
            run = $urandom_range(1, 25);
            for (int j = 0; j < run; j++) begin
                pcup0 = 1'($urandom_range(0, 1));
                pcup1 = 1'($urandom_range(0, 1));
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and switch-conditioning stage directly upstream of the instruction decoder. Holds the program counter that addresses program memory, whose opcode field feeds the decoder. Advances the counter under the decoder's `PCup` strobe. Also produces the clean, debounced `Switch8` level that the decoder compares against the HOLD instruction's enable bit, so HOLD-based handshakes with the operator are glitch-free.

## Interface
- `PSIZE`, 5: program counter width; program memory depth is 2**PSIZE.
- `LAST_ADDR`, 2**PSIZE-1: address of the final instruction.
- `WRAP`, 1: 1 = PC returns to 0 after `LAST_ADDR`; 0 = PC parks at `LAST_ADDR` and `done` asserts.
- `DB_CYCLES`, 16: consecutive stable cycles required before `Switch8` changes; minimum 2.

Ports:
- `clk` in 1: system clock, rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `PCup` in 1: from decoder; 1 = advance PC this cycle, 0 = hold.
- `sw8_raw` in 1: raw board switch SW[8], asynchronous to `clk`.
- `PCout` out PSIZE: current program memory address.
- `Switch8` out 1: synchronized, debounced switch level, to decoder.
- `sw8_edge` out 1: one-cycle pulse on every `Switch8` change (rise or fall).
- `done` out 1: program finished (only when WRAP=0).

## Operation
- Reset values: `PCout`=0, `Switch8`=0, `sw8_edge`=0, `done`=0, both synchronizer flops=0, debounce counter=0. All apply immediately on `reset` assertion, regardless of clock.
- PC update, per rising edge:
  - `PCup`=0: hold.
  - `PCup`=1 and PC≠LAST_ADDR: PC+1.
  - `PCup`=1 and PC=LAST_ADDR, WRAP=1: PC becomes 0.
  - `PCup`=1 and PC=LAST_ADDR, WRAP=0: PC holds and `done` is set.
- `done` is sticky until reset. While `done`=1, `PCup` is ignored.
- PC arithmetic is unsigned PSIZE-bit. PC never exceeds LAST_ADDR, even if LAST_ADDR < 2**PSIZE-1.
- Switch conditioning: `sw8_raw` passes through a 2-flop synchronizer, `s1` then `s2`.
  - Debounce counter width: clog2(DB_CYCLES).
  - `s2`==`Switch8`: counter clears.
  - `s2`≠`Switch8` and counter<DB_CYCLES-1: counter increments.
  - `s2`≠`Switch8` and counter=DB_CYCLES-1: `Switch8` takes `s2`, counter clears, `sw8_edge`=1 for that one cycle.
- A bounce, meaning `s2` returning to `Switch8` before terminal count, discards the partial count.
- The debouncer runs independently of the PC and of `done`.
- Mid-operation reset: PC, `done` and all debounce state return to their reset values. Any pending debounce count is lost.

## Timing
- PC latency: `PCup` sampled at edge N gives the new `PCout` after edge N. There is no combinational path from `PCup` to `PCout`.
- HOLD stall: the decoder drives `PCup`=0 combinationally. PC holds for exactly as many edges as `PCup` stays low.
- Switch latency: a clean `sw8_raw` step settling before edge 1 gives `s2` updated after edge 2. `Switch8` and the `sw8_edge` pulse appear after edge DB_CYCLES+2.
- Glitch rejection: any `s2` excursion shorter than DB_CYCLES cycles produces no `Switch8` change.
- `Switch8` and `PCup` change on the same edge: the PC uses the `PCup` value sampled at that edge. The new `Switch8` affects the decoder from the following cycle.
- All outputs are registered except none; every output comes directly from a flop.

## Structure
- Shared package `picomips_pkg` holds a `PSIZE_DEFAULT` constant and a `clog2`-based width helper used for the counter.
- The opcode and ALU constant files remain separate and are not used here.
- Sub-module `sw_debounce`:
  - Contains the synchronizer, counter and edge pulse.
  - Parameter: DB_CYCLES.
  - Ports: `clk`, `reset`, `raw`, `level`, `edge_p`.
- `pc_sequencer` instantiates one `sw_debounce` and contains the PC/done logic itself.

## Test plan
- Reset and count, with PSIZE=5, WRAP=1, LAST_ADDR=31:
  - Assert `reset` mid-cycle: `PCout`=0 immediately.
  - Release and hold `PCup`=1 for 33 edges: `PCout` goes 1..31, 0, 1.
  - `done` stays 0 throughout.
- Park at end, with WRAP=0, LAST_ADDR=9:
  - After 9 `PCup` edges, `PCout`=9 and `done`=0.
  - On the 10th edge, `done`=1 and `PCout`=9.
  - Further `PCup` pulses leave `PCout`=9.
- HOLD stall:
  - Drive `PCup`=0 for 5 edges at `PCout`=4: `PCout` stays 4.
  - Return `PCup`=1: `PCout`=5 after the next edge.
- Clean switch, with DB_CYCLES=16:
  - Step `sw8_raw` 0→1 and hold: `Switch8` rises after edge 18.
  - `sw8_edge` is high for exactly that one cycle.
  - Step back to 0: `Switch8` falls 18 edges later with one `sw8_edge` pulse.
- Bounce rejection:
  - Toggle `sw8_raw` with high periods of 10 cycles, then hold high.
  - No `Switch8` change occurs until 16 consecutive stable `s2` cycles have elapsed.
  - Exactly one `sw8_edge` pulse.
- Reset mid-debounce:
  - Assert `reset` 8 cycles into a counting rise.
  - After release with `sw8_raw` still 1, `Switch8` rises exactly DB_CYCLES+2 edges later.
  - `PCout` is 0 after the reset.
